// File: rtl/demux_row_loader.sv
// demux_row_loader: sequences a valid/ready byte stream onto N demux lanes,
// one byte per lane per row, counting rows against a programmed load length.
// Optional feature macro: DEMUX_ZERO_PAD_EN (zero-pads short rows via PAD).
// Ports:
//   clk, rst        clock, async active-high reset
//   start, num_rows load request and row count (sampled in IDLE)
//   in_valid/in_data/in_last/in_ready  byte stream handshake
//   sel, lane_data, lane_we            registered demux controls
//   row_done, done  one-cycle completion pulses
//   busy            load in progress
//   err             sticky short-row error
module demux_row_loader #(
    parameter int N      = 8,
    parameter int ROWS_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROWS_W-1:0]    num_rows,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [$clog2(N)-1:0] sel,
    output logic [7:0]           lane_data,
    output logic [N-1:0]         lane_we,
    output logic                 row_done,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int LW = $clog2(N);
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
`ifdef DEMUX_ZERO_PAD_EN
    localparam logic [1:0] PAD  = 2'd2;
`endif

    logic [1:0]        state;
    logic [LW-1:0]     lane_cnt;
    logic [ROWS_W-1:0] row_cnt;
    logic [ROWS_W-1:0] rows_tgt;
    logic [ROWS_W-1:0] row_nxt;
    logic              wr;
    logic              wrap;
    logic              fin;
    logic              short_row;
    logic [7:0]        wdat;

    always_comb begin
        row_nxt   = row_cnt + ROWS_W'(1);
        wr        = (state == LOAD) && in_valid;
        wdat      = in_data;
`ifdef DEMUX_ZERO_PAD_EN
        // PAD writes one zero byte per cycle, independent of the stream
        if (state == PAD) begin
            wr   = 1'b1;
            wdat = 8'h00;
        end
`endif
        wrap      = wr && (lane_cnt == LAST);
        fin       = wrap && (row_nxt == rows_tgt);
        // in_last on the final lane is an ordinary row end, not a short row
        short_row = (state == LOAD) && in_valid && in_last && !wrap;
    end

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lane_cnt  <= '0;
            row_cnt   <= '0;
            rows_tgt  <= '0;
            sel       <= '0;
            lane_data <= '0;
            lane_we   <= '0;
            row_done  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            lane_we  <= '0;
            row_done <= 1'b0;
            done     <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    err <= 1'b0;
                    if (num_rows != '0) begin
                        rows_tgt <= num_rows;
                        lane_cnt <= '0;
                        row_cnt  <= '0;
                        state    <= LOAD;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end else if (wr) begin
                lane_data <= wdat;
                sel       <= lane_cnt;
                lane_we   <= N'(1) << lane_cnt;
                unique case (1'b1)
                    wrap: begin
                        lane_cnt <= '0;
                        row_cnt  <= row_nxt;
                        row_done <= 1'b1;
                        if (fin) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                    short_row: begin
`ifdef DEMUX_ZERO_PAD_EN
                        state    <= PAD;
                        lane_cnt <= lane_cnt + LW'(1);
`else
                        // source re-sends the whole row from lane 0
                        err      <= 1'b1;
                        lane_cnt <= '0;
`endif
                    end
                    default: lane_cnt <= lane_cnt + LW'(1);
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_row_loader.sv
// tb_demux_row_loader: scoreboard bench for demux_row_loader,
// covering N=8 and N=5 instances.
module tb_demux_row_loader;

    typedef struct packed {
        logic [7:0] we;
        logic [2:0] sel;
        logic [7:0] data;
        logic       rd;
        logic       dn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start5 = 1'b0;
    logic [7:0] num_rows = '0;
    logic       in_valid = 1'b0;
    logic       in_valid5 = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;

    logic       in_ready, row_done, busy, done, err;
    logic [2:0] sel;
    logic [7:0] lane_data, lane_we;

    logic       in_ready5, row_done5, busy5, done5, err5;
    logic [2:0] sel5;
    logic [7:0] lane_data5;
    logic [4:0] lane_we5;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    demux_row_loader #(.N(8), .ROWS_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .sel(sel), .lane_data(lane_data),
        .lane_we(lane_we), .row_done(row_done), .busy(busy),
        .done(done), .err(err)
    );

    demux_row_loader #(.N(5), .ROWS_W(8)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .num_rows(num_rows),
        .in_valid(in_valid5), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready5), .sel(sel5), .lane_data(lane_data5),
        .lane_we(lane_we5), .row_done(row_done5), .busy(busy5),
        .done(done5), .err(err5)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t mk(int lane, logic [7:0] d, logic rd, logic dn);
        exp_t r;
        r.we   = 8'(32'd1 << lane);
        r.sel  = 3'(lane);
        r.data = d;
        r.rd   = rd;
        r.dn   = dn;
        return r;
    endfunction

    task automatic do_start(input logic [7:0] n);
        start    = 1'b1;
        num_rows = n;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, sel, lane_data, lane_we, row_done, busy, done, err} !== '0) begin
            n_bad++;
            $display("FAIL reset8: got %h required 0",
                     {in_ready, sel, lane_data, lane_we, row_done, busy, done, err});
        end
        n_cmp++;
        if ({in_ready5, sel5, lane_data5, lane_we5, row_done5, busy5, done5, err5} !== '0) begin
            n_bad++;
            $display("FAIL reset5: got %h required 0",
                     {in_ready5, sel5, lane_data5, lane_we5, row_done5, busy5, done5, err5});
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t o;
        int   busy_n = 0;
        do_start(8'd2);
        if (busy) busy_n++;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready: got %b required 1", in_ready);
        end
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(16 + i);
            in_last  = (i % 8 == 7);
            sb.push_back(mk(i % 8, in_data, i % 8 == 7, i == 15));
            @(posedge clk); #1;
            if (busy) busy_n++;
            e = sb.pop_front();
            o = {lane_we, sel, lane_data, row_done, done};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL b2b_byte%0d: got %h required %h", i, o, e);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++;
        if (busy_n != 16) begin
            n_bad++;
            $display("FAIL b2b_busy: got %0d cycles required 16", busy_n);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({lane_we, row_done, done} !== '0) begin
            n_bad++;
            $display("FAIL b2b_idle: got %h required 0", {lane_we, row_done, done});
        end
    endtask

    task automatic test_random_gaps();
        exp_t e;
        exp_t o;
        bit   v;
        int   sent = 0;
        int   strobes = 0;
        int   cyc = 0;
        do_start(8'd3);
        while (sent < 24 && cyc < 400) begin
            v        = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = 8'($urandom);
            in_last  = v && (sent % 8 == 7);
            if (v) begin
                sb.push_back(mk(sent % 8, in_data, sent % 8 == 7, sent == 23));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (lane_we != '0) strobes++;
            if (v || lane_we != '0) begin
                n_cmp++;
                if (!v || sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL gap_strobe: got lane_we %h required 00", lane_we);
                end else begin
                    e = sb.pop_front();
                    o = {lane_we, sel, lane_data, row_done, done};
                    if (o !== e) begin
                        n_bad++;
                        $display("FAIL gap_byte%0d: got %h required %h", sent - 1, o, e);
                    end
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++;
        if (strobes != 24 || sent != 24 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL gap_count: got %0d strobes required 24", strobes);
        end
        sb.delete();
    endtask

    task automatic test_short_row();
        exp_t e;
        exp_t o;
`ifdef DEMUX_ZERO_PAD_EN
        int   rdy0 = 0;
        do_start(8'd2);
`else
        do_start(8'd1);
`endif
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            in_last  = (i == 2);
            sb.push_back(mk(i, in_data, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {lane_we, sel, lane_data, row_done, done};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL short_byte%0d: got %h required %h", i, o, e);
            end
        end
`ifdef DEMUX_ZERO_PAD_EN
        if (!in_ready) rdy0++;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        in_last  = 1'b0;
        for (int p = 3; p < 8; p++) begin
            sb.push_back(mk(p, 8'h00, p == 7, 1'b0));
            @(posedge clk); #1;
            if (p < 7 && !in_ready) rdy0++;
            e = sb.pop_front();
            o = {lane_we, sel, lane_data, row_done, done};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL pad_lane%0d: got %h required %h", p, o, e);
            end
        end
        n_cmp++;
        if (rdy0 != 5 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL pad_ready: got %0d low cycles, ready %b required 5, 1", rdy0, in_ready);
        end
`else
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL short_err: got %b required 1", err);
        end
`endif
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hB0 + i);
            in_last  = (i == 7);
            sb.push_back(mk(i, in_data, i == 7, i == 7));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {lane_we, sel, lane_data, row_done, done};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL short_next%0d: got %h required %h", i, o, e);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_zero_rows();
`ifdef DEMUX_ZERO_PAD_EN
        logic exp_err = 1'b0;
`else
        logic exp_err = 1'b1;
`endif
        n_cmp++;
        if (err !== exp_err) begin
            n_bad++;
            $display("FAIL zero_err_before: got %b required %b", err, exp_err);
        end
        do_start(8'd0);
        n_cmp++;
        if ({done, busy, lane_we, err} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL zero_done: got %h required %h",
                     {done, busy, lane_we, err}, {1'b1, 1'b0, 8'h00, 1'b0});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy, lane_we} !== '0) begin
            n_bad++;
            $display("FAIL zero_after: got %h required 0", {done, busy, lane_we});
        end
    endtask

    task automatic test_reset_mid_row();
        exp_t e;
        exp_t o;
        do_start(8'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h30 + i);
            in_last  = 1'b0;
            sb.push_back(mk(i, in_data, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {lane_we, sel, lane_data, row_done, done};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rst_pre%0d: got %h required %h", i, o, e);
            end
        end
        in_data = 8'h34;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, sel, lane_data, lane_we, row_done, busy, done, err} !== '0) begin
            n_bad++;
            $display("FAIL rst_async: got %h required 0",
                     {in_ready, sel, lane_data, lane_we, row_done, busy, done, err});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_start(8'd1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + i);
            in_last  = (i == 7);
            start    = (i == 3);
            num_rows = (i == 3) ? 8'd5 : 8'd1;
            sb.push_back(mk(i, in_data, i == 7, i == 7));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {lane_we, sel, lane_data, row_done, done};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rst_reload%0d: got %h required %h", i, o, e);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++;
        if ({busy, in_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_end: got %b required 00", {busy, in_ready});
        end
    endtask

    task automatic test_n5();
        exp_t e;
        exp_t o;
        start5   = 1'b1;
        num_rows = 8'd2;
        @(posedge clk); #1;
        start5   = 1'b0;
        n_cmp++;
        if (in_ready5 !== 1'b1) begin
            n_bad++;
            $display("FAIL n5_ready: got %b required 1", in_ready5);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid5 = 1'b1;
            in_data   = 8'(8'h50 + i);
            in_last   = (i % 5 == 4);
            sb.push_back(mk(i % 5, in_data, i % 5 == 4, i == 9));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {3'b000, lane_we5, sel5, lane_data5, row_done5, done5};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL n5_byte%0d: got %h required %h", i, o, e);
            end
        end
        in_valid5 = 1'b0;
        in_last   = 1'b0;
        n_cmp++;
        if ({busy5, err5} !== 2'b00) begin
            n_bad++;
            $display("FAIL n5_end: got %b required 00", {busy5, err5});
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_random_gaps();
        test_short_row();
        test_zero_rows();
        test_reset_mid_row();
        test_n5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_row_loader.md
# demux_row_loader

Sequencing controller for the 1-to-N byte demultiplexer that fans operand bytes out to the N lanes of the systolic array. It accepts a valid/ready byte stream, steps the lane select 0..N-1 for each row, and issues a one-hot per-lane write strobe so that each lane buffer captures exactly one byte per row. It counts rows against a programmed load length and reports row and load completion.

## Interface
- N, 8: number of lanes; any value ≥ 2, power of two not required.
- ROWS_W, 8: width of the row-count configuration.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle load request; sampled only in IDLE.
- num_rows  in  ROWS_W  rows to load; sampled with start.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_last  in  1  end-of-row marker, qualified by in_valid.
- in_ready  out  1  stream ready.
- sel  out  $clog2(N)  registered lane select driven to the demux.
- lane_data  out  8  registered byte driven to the demux data input.
- lane_we  out  N  one-hot lane write strobe.
- row_done  out  1  one-cycle pulse when a row completes.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  sticky short-row error; cleared by an accepted start.

## Operation
- States: IDLE, LOAD, and PAD (PAD exists only with the macro). Internal lane_cnt (0..N-1), row_cnt (ROWS_W), and latched rows_tgt.
- IDLE: in_ready=0, busy=0. An accepted start with num_rows≠0 latches rows_tgt, clears lane_cnt, row_cnt and err, and moves to LOAD. An accepted start with num_rows=0 pulses done on the next cycle, clears err, and stays in IDLE.
- LOAD: in_ready=1. A handshake occurs when in_valid and in_ready are both high. On each handshake, next cycle: lane_data=in_data, sel=lane_cnt, lane_we=1<<lane_cnt for one cycle. lane_cnt increments.
- Row completion: a handshake at lane_cnt=N-1 wraps lane_cnt to 0, increments row_cnt, and pulses row_done together with that lane_we. in_last is not required at lane N-1.
- Load completion: when the completing row makes row_cnt equal rows_tgt, done pulses in the same cycle as the final row_done and the block returns to IDLE, so busy is low in that cycle.
- Short row: in_last with lane_cnt<N-1. The byte itself is still written normally. The remainder of the row follows the Configuration section.
- start outside IDLE is ignored. No handshake occurs while in_valid is low, and all outputs hold, except that the lane_we, row_done and done pulses drop to 0.
- Reset, including mid-load, immediately forces IDLE and zeroes all counters and outputs. Any partial row is discarded.

## Timing
- Reset values: in_ready=0, sel=0, lane_data=0, lane_we=0, row_done=0, busy=0, done=0, err=0.
- Latency is one cycle from handshake to lane_we, sel and lane_data. sel and lane_data hold their last values between writes.
- Throughput is one byte per cycle in LOAD. in_ready rises the cycle after start is accepted.
- busy is high from the cycle after start through the cycle before done.
- in_ready is combinational from state only and has no dependency on in_valid.

## Configuration
- DEMUX_ZERO_PAD_EN defined: a short row moves to PAD with in_ready=0. PAD writes 8'h00 to each remaining lane, one per cycle, using the same lane_we, sel and row_done timing as LOAD. After lane N-1, it returns to LOAD, or to IDLE with done if the load is complete. err is never set.
- Not defined: a short row sets err. lane_cnt resets to 0, row_cnt is unchanged, and no row_done is issued. The partial row is re-sent in full by the source. PAD state is not synthesised.

## Test plan
- N=8, start with num_rows=2, 16 back-to-back bytes 0x10..0x1F, in_last on bytes 7 and 15. Required: lane_we walks 0x01..0x80 twice, sel 0..7, lane_data matches each byte one cycle later, row_done pulses twice, done coincides with the second row_done, busy lasts 16 cycles.
- Random in_valid gaps (≈50%) with num_rows=3. Required: the lane_we count is exactly 24, no strobe occurs in gap cycles, and the lane order is preserved.
- Short row: in_last on the 3rd byte (0xA2). Required with the macro: lane_we for lanes 3..7 with lane_data=0x00, in_ready=0 for 5 cycles, then row_done. Required without it: err=1, no row_done, and the next byte goes to lane 0.
- start with num_rows=0. Required: done pulses one cycle later, busy stays 0, and there is no lane_we.
- rst asserted mid-row at lane 4. Required: all outputs are 0 immediately. A new start with num_rows=1 then loads from lane 0, and a start issued while busy is ignored.
- N=5: 10 bytes with num_rows=2. Required: sel wraps 4→0 and lane_we takes values 5'b00001..5'b10000 only.
